useq: RTL and testbench

USEQ -- requirements
Module: useq

---
 rtl/useq_pkg.sv | 39 +++
 rtl/useq_next.sv | 45 ++++
 rtl/useq.sv | 109 ++++++++++
 tb/tb_useq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/useq_pkg.sv
// Shared constants, microinstruction field layout and enums for the useq microsequencer.
package useq_pkg;

  localparam int unsigned ADDR_W        = 5;
  localparam int unsigned WORD_W        = 23;
  localparam int unsigned ROM_DEPTH_DEF = 18;
  localparam int unsigned COND_W        = 3;
  localparam int unsigned CTRL_W        = 15;
  localparam int unsigned STEP_W        = 8;

  // Microinstruction layout: [22:20] code, [19:15] branch, [14:0] control.
  localparam int unsigned CC_MSB   = 22;
  localparam int unsigned CC_LSB   = 20;
  localparam int unsigned BR_MSB   = 19;
  localparam int unsigned BR_LSB   = 15;
  localparam int unsigned CTRL_MSB = 14;
  localparam int unsigned CTRL_LSB = 0;

  localparam logic [STEP_W-1:0] STEP_MAX = '1;

  typedef enum logic [2:0] {
    CC_ALWAYS = 3'd0,
    CC_C0     = 3'd1,
    CC_C1     = 3'd2,
    CC_C2     = 3'd3,
    CC_HALT   = 3'd4,
    CC_RSV5   = 3'd5,
    CC_RSV6   = 3'd6,
    CC_RSV7   = 3'd7
  } cond_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/useq_next.sv
// Next-address logic: branch selection, halt detection and control-store range check.
module useq_next
  import useq_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int unsigned ADDR_W    = useq_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] i_upc,
  input  logic [COND_W-1:0] i_code,
  input  logic [ADDR_W-1:0] i_br,
  input  logic [COND_W-1:0] i_cond,
  output logic [ADDR_W-1:0] o_next_c,
  output logic              o_halt_c,
  output logic              o_range_err_c
);

  localparam int unsigned NW = ADDR_W + 1;
  localparam logic [NW-1:0] DEPTH = NW'(ROM_DEPTH);

  cond_code_e       w_code;
  logic [NW-1:0]    w_seq;
  logic [NW-1:0]    w_tgt;
  logic [NW-1:0]    w_next;

  assign w_code = cond_code_e'(i_code);
  // One extra bit so uPC+1 past the top address cannot wrap back into range.
  assign w_seq  = NW'(i_upc) + NW'(1);
  assign w_tgt  = NW'(i_br);

  always_comb begin
    w_next = w_seq;
    case (w_code)
      CC_ALWAYS, CC_HALT: w_next = w_tgt;
      CC_C0:              w_next = i_cond[0] ? w_tgt : w_seq;
      CC_C1:              w_next = i_cond[1] ? w_tgt : w_seq;
      CC_C2:              w_next = i_cond[2] ? w_tgt : w_seq;
      default:            w_next = w_seq;
    endcase
  end

  assign o_next_c      = ADDR_W'(w_next);
  assign o_halt_c      = (w_code == CC_HALT) && (i_br == i_upc);
  assign o_range_err_c = (w_next >= DEPTH);

endmodule

// File: rtl/useq.sv
// Microprogram sequencer with external control ROM.
// Optional watchdog enabled by defining USEQ_WDOG_EN.
module useq
  import useq_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int unsigned ADDR_W    = useq_pkg::ADDR_W,
  parameter int unsigned WORD_W    = useq_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [COND_W-1:0] cond_i,
  input  logic [WORD_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [CTRL_W-1:0] ctrl,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] step_cnt
);

  state_e            r_state;
  state_e            w_state_n;
  logic [ADDR_W-1:0] r_upc;
  logic [ADDR_W-1:0] w_upc_n;
  logic [STEP_W-1:0] r_step_cnt;
  logic [STEP_W-1:0] w_step_n;
  logic [ADDR_W-1:0] w_next;
  logic              w_halt;
  logic              w_range_err;

  useq_next #(
    .ROM_DEPTH (ROM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_next (
    .i_upc         (r_upc),
    .i_code        (rom_data[CC_MSB:CC_LSB]),
    .i_br          (ADDR_W'(rom_data[BR_MSB:BR_LSB])),
    .i_cond        (cond_i),
    .o_next_c      (w_next),
    .o_halt_c      (w_halt),
    .o_range_err_c (w_range_err)
  );

  // State, uPC and step counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_upc      <= '0;
      r_step_cnt <= '0;
    end else begin
      r_state    <= w_state_n;
      r_upc      <= w_upc_n;
      r_step_cnt <= w_step_n;
    end
  end

  // Next-state: halt wins over range error; uPC is frozen on DONE/ERR entry.
  always_comb begin
    w_state_n = r_state;
    w_upc_n   = r_upc;
    w_step_n  = r_step_cnt;
    case (r_state)
      ST_RUN: begin
        w_step_n = (r_step_cnt == STEP_MAX) ? r_step_cnt : r_step_cnt + STEP_W'(1);
        if (w_halt) begin
          w_state_n = ST_DONE;
        end else if (w_range_err) begin
          w_state_n = ST_ERR;
`ifdef USEQ_WDOG_EN
        end else if (r_step_cnt == STEP_MAX) begin
          w_state_n = ST_ERR;
`endif
        end else begin
          w_upc_n = w_next;
        end
      end
      default: begin
        if (start) begin
          w_state_n = ST_RUN;
          w_upc_n   = '0;
          w_step_n  = '0;
        end
      end
    endcase
  end

  // Outputs decoded from the current state; ctrl passes the ROM word through only in RUN.
  always_comb begin
    ctrl = '0;
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    case (r_state)
      ST_RUN: begin
        ctrl = rom_data[CTRL_MSB:CTRL_LSB];
        busy = 1'b1;
      end
      ST_DONE: done = 1'b1;
      ST_ERR:  err  = 1'b1;
      default: ;
    endcase
  end

  assign rom_addr = r_upc;
  assign step_cnt = r_step_cnt;

endmodule

// File: tb/tb_useq.sv
// Directed bench for useq with a behavioural control ROM driven from rom_addr.
module tb_useq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  cond_i;
  logic [22:0] rom_data;
  logic [4:0]  rom_addr;
  logic [14:0] ctrl;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  step_cnt;

  logic [22:0] rom [0:31];
  int          n_asserts = 0;
  int          n_fail    = 0;
  int          seq38 [10] = '{0, 1, 2, 3, 12, 13, 14, 15, 16, 17};

  useq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cond_i   (cond_i),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .ctrl     (ctrl),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .step_cnt (step_cnt)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] mk(input int code, input int br, input int c);
    return {3'(code), 5'(br), 15'(c)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = '0;
  endtask

  // Production program: 0..2 straight, 3 tests cond[0] to 12, 8 skips to 10, 11 loops to 3, 17 halts.
  task automatic load_prod();
    clear_rom();
    for (int i = 0; i < 18; i++) rom[i] = mk(0, i + 1, 16'h100 + i);
    rom[3]  = mk(1, 12, 16'h103);
    rom[8]  = mk(0, 10, 16'h108);
    rom[11] = mk(0, 3,  16'h10b);
    rom[17] = mk(4, 17, 16'h111);
  endtask

  function automatic int loop_next(input int a);
    if (a == 8)  return 10;
    if (a == 11) return 3;
    return a + 1;
  endfunction

  initial begin
    int  exp_a;
    bit  found;
    reset  = 1'b1;
    start  = 1'b0;
    cond_i = 3'b000;
    load_prod();
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err",  err, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_step", step_cnt, 0);
    check("rst_ctrl", ctrl, 0);
    reset = 1'b0;

    // Full program run to halt with cond[0] set.
    cond_i = 3'b001;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("run_addr", rom_addr, seq38[i]);
      check("run_busy", busy, 1);
      check("run_ctrl", ctrl, 32'h100 + seq38[i]);
      @(negedge clk);
    end
    check("halt_done", done, 1);
    check("halt_busy", busy, 0);
    check("halt_step", step_cnt, 10);
    check("halt_addr", rom_addr, 17);
    check("halt_ctrl", ctrl, 0);

    // Restart from DONE, then loop with cond clear; start mid-RUN is ignored.
    cond_i = 3'b000;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rs_done", done, 0);
    check("rs_busy", busy, 1);
    check("rs_addr", rom_addr, 0);
    check("rs_step", step_cnt, 0);
    exp_a = 0;
    for (int i = 0; i < 24; i++) begin
      check("loop_addr", rom_addr, exp_a);
      start = (exp_a == 5);
      @(negedge clk);
      exp_a = loop_next(exp_a);
    end
    start = 1'b0;
    check("loop_step", step_cnt, 24);
    repeat (300) @(negedge clk);
`ifdef USEQ_WDOG_EN
    check("wdog_err",  err, 1);
    check("wdog_busy", busy, 0);
`else
    check("sat_busy", busy, 1);
    check("sat_err",  err, 0);
`endif
    check("sat_step", step_cnt, 255);

    // Reset in the middle of a program.
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    cond_i = 3'b001;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rom_addr == 5'd13) found = 1'b1;
      else @(negedge clk);
    end
    check("mid_reach13", found, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_addr", rom_addr, 0);
    check("mid_step", step_cnt, 0);
    check("mid_ctrl", ctrl, 0);
    check("mid_done", done, 0);
    check("mid_err",  err, 0);
    @(negedge clk);
    check("mid_idle", busy, 0);

    // Branch out of range from word 0.
    clear_rom();
    rom[0] = mk(0, 20, 16'h7abc);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("oor_busy", busy, 1);
    check("oor_ctrl_run", ctrl, 32'h7abc);
    @(negedge clk);
    check("oor_err",  err, 1);
    check("oor_ctrl", ctrl, 0);
    check("oor_addr", rom_addr, 0);
    check("oor_busy_off", busy, 0);
    check("oor_step", step_cnt, 1);

    // Reserved code falls through; restart from ERR.
    rom[0] = mk(5, 9, 16'h0011);
    rom[1] = mk(4, 1, 16'h0022);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rsv_err_clr", err, 0);
    check("rsv_busy", busy, 1);
    check("rsv_addr0", rom_addr, 0);
    @(negedge clk);
    check("rsv_addr1", rom_addr, 1);
    check("rsv_ctrl", ctrl, 32'h22);
    @(negedge clk);
    check("rsv_done", done, 1);
    check("rsv_step", step_cnt, 2);

    // Codes 3 and 2, and uPC+1 landing exactly on ROM_DEPTH.
    clear_rom();
    rom[0]  = mk(3, 17, 1);
    rom[17] = mk(2, 5, 2);
    cond_i  = 3'b100;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("edge_addr0", rom_addr, 0);
    @(negedge clk);
    check("edge_addr17", rom_addr, 17);
    @(negedge clk);
    check("edge_err", err, 1);
    check("edge_addr", rom_addr, 17);
    check("edge_step", step_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
